servo_uart_rx: RTL and testbench

- UART receiver, 8N1, for the servo PWM subsystem.
- Accepts serial angle commands from a host terminal (PuTTY, 9600 baud) and decodes ASCII '0', '1', '2' into the 2-bit servo angle select that drives the PWM generator's angle input.
- It is the receive counterpart of the existing duty-cycle UART transmitter and sits between the board RX pin and the PWM generator select input.

---
 rtl/servo_uart_rx.sv | 178 +++++++++++++++++
 tb/tb_servo_uart_rx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/servo_uart_rx.sv
// 8N1 UART receiver for the servo PWM subsystem.
// Decodes ASCII '0'/'1'/'2' into the PWM angle select.
module servo_uart_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_WIDTH    = 13,
    parameter int SEL_WIDTH    = 2
) (
    input  logic                 Clk_i,
    input  logic                 Reset_i,
    input  logic                 Rx_i,
    output logic [7:0]           Data_o,
    output logic                 Valid_o,
    output logic                 Frame_err_o,
    output logic [SEL_WIDTH-1:0] Sel_o
);

    localparam logic [CNT_WIDTH-1:0] BIT_LAST  = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [CNT_WIDTH-1:0] HALF_LAST = CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    localparam logic [SEL_WIDTH-1:0] SEL_0   = SEL_WIDTH'(0);
    localparam logic [SEL_WIDTH-1:0] SEL_90  = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0] SEL_180 = SEL_WIDTH'(2);

    if (CLKS_PER_BIT < 8) begin : g_bad_clks
        $error("servo_uart_rx: CLKS_PER_BIT must be >= 8");
    end
    if ((64'd1 << CNT_WIDTH) <= 64'(CLKS_PER_BIT)) begin : g_bad_cnt
        $error("servo_uart_rx: CNT_WIDTH too narrow for CLKS_PER_BIT");
    end
    if (SEL_WIDTH < 2) begin : g_bad_sel
        $error("servo_uart_rx: SEL_WIDTH must be >= 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic                   rx_meta;
    logic                   rx_s;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_n;
    logic [2:0]             idx;
    logic [2:0]             idx_n;
    logic [7:0]             shreg;
    logic [7:0]             shreg_n;
    logic [7:0]             data_q;
    logic [7:0]             data_n;
    logic                   valid_q;
    logic                   valid_n;
    logic                   ferr_q;
    logic                   ferr_n;
    logic [SEL_WIDTH-1:0]   sel_q;
    logic [SEL_WIDTH-1:0]   sel_n;
    logic [SEL_WIDTH-1:0]   cmd_sel;

    // Rx_i is asynchronous; idle-high so both stages reset to 1
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= Rx_i;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            sel_q   <= SEL_0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            ferr_q  <= ferr_n;
            sel_q   <= sel_n;
        end
    end

    // Unknown bytes (CR/LF etc.) keep the current angle
    always_comb begin
        cmd_sel = sel_q;
        case (shreg)
            8'h30:   cmd_sel = SEL_0;
            8'h31:   cmd_sel = SEL_90;
            8'h32:   cmd_sel = SEL_180;
            default: cmd_sel = sel_q;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = data_q;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        sel_n   = sel_q;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    cnt_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                        sel_n   = cmd_sel;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            // A held-low line (break) must not look like a new start bit
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign Data_o      = data_q;
    assign Valid_o     = valid_q;
    assign Frame_err_o = ferr_q;
    assign Sel_o       = sel_q;

endmodule

// File: tb/tb_servo_uart_rx.sv
// Directed bench for servo_uart_rx: fast instance (16 clk/bit)
// and a default-timing instance driven by a 2% fast transmitter.
module tb_servo_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic       valid_a;
    logic       valid_b;
    logic       ferr_a;
    logic       ferr_b;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int vcnt_a = 0;
    int fcnt_a = 0;
    int vcnt_b = 0;
    int fcnt_b = 0;
    int viol = 0;
    int cyc_valid_b = 0;
    logic [1:0] sel_log[$];
    logic [7:0] data_log[$];

    localparam int FB = 16;

    servo_uart_rx #(.CLKS_PER_BIT(FB), .CNT_WIDTH(5), .SEL_WIDTH(2)) u_a (
        .Clk_i(clk), .Reset_i(rst), .Rx_i(rx_a),
        .Data_o(data_a), .Valid_o(valid_a), .Frame_err_o(ferr_a), .Sel_o(sel_a)
    );

    servo_uart_rx u_b (
        .Clk_i(clk), .Reset_i(rst), .Rx_i(rx_b),
        .Data_o(data_b), .Valid_o(valid_b), .Frame_err_o(ferr_b), .Sel_o(sel_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_a) begin
            vcnt_a++;
            sel_log.push_back(sel_a);
            data_log.push_back(data_a);
        end
        if (ferr_a) fcnt_a++;
        if (valid_b) begin
            vcnt_b++;
            cyc_valid_b = cyc;
        end
        if (ferr_b) fcnt_b++;
        if ((valid_a && ferr_a) || sel_a == 2'b11) viol++;
        if ((valid_b && ferr_b) || sel_b == 2'b11) viol++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit line_b, input logic v, input int n);
        if (line_b) rx_b = v;
        else rx_a = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit line_b, input logic [7:0] b, input int clks,
                        input int stop_clks, input logic stop_v);
        drive(line_b, 1'b0, clks);
        for (int i = 0; i < 8; i++) drive(line_b, b[i], clks);
        drive(line_b, stop_v, stop_clks);
    endtask

    int v0;
    int f0;
    int t0;

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(data_a), 32'h00);
        check("rst_valid", 32'(valid_a), 32'h0);
        check("rst_ferr", 32'(ferr_a), 32'h0);
        check("rst_sel", 32'(sel_a), 32'h0);
        rst = 1'b0;
        drive(1'b0, 1'b1, 2 * FB);

        // good '1' frame
        v0 = vcnt_a; f0 = fcnt_a;
        send(1'b0, 8'h31, FB, FB, 1'b1);
        drive(1'b0, 1'b1, FB);
        check("t1_vcnt", 32'(vcnt_a - v0), 32'd1);
        check("t1_data", 32'(data_a), 32'h31);
        check("t1_sel", 32'(sel_a), 32'h1);
        check("t1_ferr", 32'(fcnt_a - f0), 32'd0);

        // '2', CR, '0' back to back
        sel_log.delete(); data_log.delete();
        v0 = vcnt_a;
        send(1'b0, 8'h32, FB, FB, 1'b1);
        send(1'b0, 8'h0D, FB, FB, 1'b1);
        send(1'b0, 8'h30, FB, FB, 1'b1);
        drive(1'b0, 1'b1, FB);
        check("t2_vcnt", 32'(vcnt_a - v0), 32'd3);
        check("t2_sel0", 32'(sel_log[0]), 32'h2);
        check("t2_sel1", 32'(sel_log[1]), 32'h2);
        check("t2_sel2", 32'(sel_log[2]), 32'h0);
        check("t2_dat0", 32'(data_log[0]), 32'h32);
        check("t2_dat1", 32'(data_log[1]), 32'h0D);
        check("t2_dat2", 32'(data_log[2]), 32'h30);

        // framing error: stop held low 3 bit times
        v0 = vcnt_a; f0 = fcnt_a;
        send(1'b0, 8'h32, FB, 3 * FB, 1'b0);
        drive(1'b0, 1'b1, 2 * FB);
        check("t3_ferr", 32'(fcnt_a - f0), 32'd1);
        check("t3_vcnt", 32'(vcnt_a - v0), 32'd0);
        check("t3_data", 32'(data_a), 32'h30);
        check("t3_sel", 32'(sel_a), 32'h0);
        send(1'b0, 8'h31, FB, FB, 1'b1);
        drive(1'b0, 1'b1, FB);
        check("t3_sel_next", 32'(sel_a), 32'h1);

        // reset during data bit 4 of 0x32
        v0 = vcnt_a; f0 = fcnt_a;
        drive(1'b0, 1'b0, FB);
        for (int i = 0; i < 4; i++) drive(1'b0, (8'h32 >> i) & 8'h01, FB);
        drive(1'b0, 1'b1, FB / 2);
        #2 rst = 1'b1;
        #1;
        check("t5_sel", 32'(sel_a), 32'h0);
        check("t5_data", 32'(data_a), 32'h00);
        check("t5_valid", 32'(valid_a), 32'h0);
        rx_a = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b0, 1'b1, 2 * FB);
        check("t5_nopulse", 32'(vcnt_a - v0 + fcnt_a - f0), 32'd0);
        send(1'b0, 8'h31, FB, FB, 1'b1);
        drive(1'b0, 1'b1, FB);
        check("t5_sel_next", 32'(sel_a), 32'h1);
        check("t5_data_next", 32'(data_a), 32'h31);

        // start-bit glitch, then 0x30
        v0 = vcnt_a; f0 = fcnt_a;
        drive(1'b0, 1'b0, FB / 4);
        drive(1'b0, 1'b1, 2 * FB);
        check("t4_glitch", 32'(vcnt_a - v0 + fcnt_a - f0), 32'd0);
        send(1'b0, 8'h30, FB, FB, 1'b1);
        drive(1'b0, 1'b1, FB);
        check("t4_vcnt", 32'(vcnt_a - v0), 32'd1);
        check("t4_data", 32'(data_a), 32'h30);
        check("t4_sel", 32'(sel_a), 32'h0);

        // default timing, transmitter 2% fast (5106 clk/bit)
        t0 = cyc;
        send(1'b1, 8'h32, 5106, 5106, 1'b1);
        drive(1'b1, 1'b1, 100);
        check("t6_vcnt", 32'(vcnt_b), 32'd1);
        check("t6_ferr", 32'(fcnt_b), 32'd0);
        check("t6_data", 32'(data_b), 32'h32);
        check("t6_sel", 32'(sel_b), 32'h2);
        check("t6_latency_ok",
              32'((cyc_valid_b - t0 <= 49479) && (cyc_valid_b - t0 >= 49400)),
              32'd1);

        check("never_both_or_11", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
